// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the rv32i pipeline stall/flush sequencer (pipe_ctrl).
// Holds the sequencer state encoding and the bundle of stage-register controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    SQUASH   = 2'd2
  } pipe_ctrl_state_t;

  // Load enables for PC and the four stage registers, plus bubble injects.
  typedef struct packed {
    logic load_pc;
    logic load_ifid;
    logic load_idex;
    logic load_exmem;
    logic load_memwb;
    logic flush_ifid;
    logic flush_idex;
  } stage_load_t;

  // Everything held: used while waiting on memory.
  function automatic stage_load_t sl_freeze();
    stage_load_t s;
    s = '{load_pc: 1'b0, load_ifid: 1'b0, load_idex: 1'b0, load_exmem: 1'b0,
          load_memwb: 1'b0, flush_ifid: 1'b0, flush_idex: 1'b0};
    return s;
  endfunction

  // Normal flow: every stage advances.
  function automatic stage_load_t sl_run();
    stage_load_t s;
    s = '{load_pc: 1'b1, load_ifid: 1'b1, load_idex: 1'b1, load_exmem: 1'b1,
          load_memwb: 1'b1, flush_ifid: 1'b0, flush_idex: 1'b0};
    return s;
  endfunction

  // Taken branch/jump: everything advances, both younger stages become bubbles.
  function automatic stage_load_t sl_redirect();
    stage_load_t s;
    s = '{load_pc: 1'b1, load_ifid: 1'b1, load_idex: 1'b1, load_exmem: 1'b1,
          load_memwb: 1'b1, flush_ifid: 1'b1, flush_idex: 1'b1};
    return s;
  endfunction

  // Load-use: PC and IF/ID hold, a bubble enters EX, the back end drains.
  function automatic stage_load_t sl_bubble();
    stage_load_t s;
    s = '{load_pc: 1'b0, load_ifid: 1'b0, load_idex: 1'b1, load_exmem: 1'b1,
          load_memwb: 1'b1, flush_ifid: 1'b0, flush_idex: 1'b1};
    return s;
  endfunction

  // Reset: nothing loads, both flushes asserted.
  function automatic stage_load_t sl_reset();
    stage_load_t s;
    s = '{load_pc: 1'b0, load_ifid: 1'b0, load_idex: 1'b0, load_exmem: 1'b0,
          load_memwb: 1'b0, flush_ifid: 1'b1, flush_idex: 1'b1};
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX load destination and ID sources.
// Purely combinational so the forwarding unit can reuse it.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             loaduse
);

  logic rd_nonzero_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  // x0 never creates a dependency, so a load into x0 cannot stall.
  assign rd_nonzero_s = (ex_rd != {REG_W{1'b0}});
  assign rs1_hit_s    = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit_s    = id_use_rs2 & (id_rs2 == ex_rd);
  assign loaduse      = ex_valid & ex_is_load & rd_nonzero_s & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage rv32i pipeline.
// Optional build macro: PIPE_CTRL_PERF_EN enables the 32-bit perf counters;
// without it the perf_* ports are tied to zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int TIMEOUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_valid,
  input  logic             ex_br_taken,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exmem,
  output logic             load_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             pc_sel,
  output logic             stall,
  output logic             mem_timeout,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_flush,
  output logic [31:0]      perf_loaduse
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  pipe_ctrl_state_t     state_q, state_d;
  logic                 stale_q, stale_d;   // redirect seen while its fetch was outstanding
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  logic        imem_wait_s, dmem_wait_s, mem_busy_s, redirect_s, loaduse_s;
  stage_load_t ctl_s;
  logic        pc_sel_s, stall_s;

  assign imem_wait_s = imem_read & ~imem_resp;
  assign dmem_wait_s = dmem_req & ~dmem_resp;
  assign mem_busy_s  = imem_wait_s | dmem_wait_s;
  assign redirect_s  = ex_valid & ex_br_taken;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .loaduse    (loaduse_s)
  );

  // State register with synchronous reset; reset also drops any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
    end
  end

  // Next-state logic. EX is frozen while waiting, so a held redirect is simply
  // re-evaluated from the (unchanged) EX inputs when the wait ends.
  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    case (state_q)
      RUN: begin
        if (mem_busy_s) begin
          if (redirect_s & imem_wait_s & ~dmem_wait_s) begin
            // Only the wrong-path fetch is outstanding: squash it when it returns.
            state_d = SQUASH;
            stale_d = 1'b0;
          end else begin
            state_d = MEM_WAIT;
            stale_d = redirect_s & imem_wait_s;
          end
        end else begin
          state_d = RUN;
          stale_d = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (mem_busy_s) begin
          if (stale_q & ~dmem_wait_s) begin
            // Data side done; what remains is the fetch issued before the redirect.
            state_d = SQUASH;
            stale_d = 1'b0;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          state_d = RUN;
          stale_d = 1'b0;
        end
      end
      SQUASH: begin
        if (mem_busy_s) begin
          state_d = SQUASH;
        end else begin
          state_d = RUN;
        end
        stale_d = 1'b0;
      end
      default: begin
        state_d = RUN;
        stale_d = 1'b0;
      end
    endcase
  end

  // Output decode: stage enables, flushes, PC select and stall for this cycle.
  always_comb begin
    ctl_s    = sl_freeze();
    pc_sel_s = 1'b0;
    stall_s  = 1'b0;
    if (rst) begin
      ctl_s = sl_reset();
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (mem_busy_s) begin
            stall_s = 1'b1;
          end else if (redirect_s) begin
            ctl_s    = sl_redirect();
            pc_sel_s = 1'b1;
          end else if (loaduse_s) begin
            ctl_s = sl_bubble();
          end else begin
            ctl_s = sl_run();
          end
        end
        SQUASH: begin
          if (mem_busy_s) begin
            stall_s = 1'b1;
          end else begin
            // Stale response lands in IF/ID as a bubble; PC takes the held EX target.
            ctl_s    = sl_redirect();
            pc_sel_s = 1'b1;
          end
        end
        default: begin
          ctl_s   = sl_freeze();
          stall_s = 1'b1;
        end
      endcase
    end
  end

  // Watchdog next-state: count stalled cycles (saturating), sticky flag at the top.
  always_comb begin
    if (stall_s) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = {TIMEOUT_W{1'b0}};
    end
    timeout_d = timeout_q | (cnt_d == CNT_MAX);
  end

  // Watchdog registers; the flag only clears on reset, the pipeline keeps waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= {TIMEOUT_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign load_pc     = ctl_s.load_pc;
  assign load_ifid   = ctl_s.load_ifid;
  assign load_idex   = ctl_s.load_idex;
  assign load_exmem  = ctl_s.load_exmem;
  assign load_memwb  = ctl_s.load_memwb;
  assign flush_ifid  = ctl_s.flush_ifid;
  assign flush_idex  = ctl_s.flush_idex;
  assign pc_sel      = pc_sel_s;
  assign stall       = stall_s;
  assign mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_loaduse_q;

  // Perf counters: an applied redirect is the only decode with load_pc and
  // flush_ifid together; a bubble is the only one with flush_idex alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q   <= 32'd0;
      perf_flush_q   <= 32'd0;
      perf_loaduse_q <= 32'd0;
    end else begin
      if (stall_s) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
      if (ctl_s.load_pc & ctl_s.flush_ifid) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end else begin
        perf_flush_q <= perf_flush_q;
      end
      if (ctl_s.flush_idex & ~ctl_s.flush_ifid) begin
        perf_loaduse_q <= perf_loaduse_q + 32'd1;
      end else begin
        perf_loaduse_q <= perf_loaduse_q;
      end
    end
  end

  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
  assign perf_loaduse = perf_loaduse_q;
`else
  assign perf_stall   = 32'd0;
  assign perf_flush   = 32'd0;
  assign perf_loaduse = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (watchdog built with TIMEOUT_W = 3).
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // {load_pc, load_ifid, load_idex, load_exmem, load_memwb, flush_ifid, flush_idex, pc_sel, stall}
  localparam logic [8:0] V_RUN    = 9'b11111_00_0_0;
  localparam logic [8:0] V_FREEZE = 9'b00000_00_0_1;
  localparam logic [8:0] V_REDIR  = 9'b11111_11_1_0;
  localparam logic [8:0] V_BUBBLE = 9'b00111_01_0_0;
  localparam logic [8:0] V_RESET  = 9'b00000_11_0_0;

  logic clk, rst;
  logic imem_read, imem_resp, dmem_req, dmem_resp;
  logic ex_valid, ex_br_taken, ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic id_use_rs1, id_use_rs2;
  logic load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic flush_ifid, flush_idex, pc_sel, stall, mem_timeout;
  logic [31:0] perf_stall, perf_flush, perf_loaduse;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_ctrl #(.REG_W(5), .TIMEOUT_W(3)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .ex_valid(ex_valid), .ex_br_taken(ex_br_taken), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
    .load_exmem(load_exmem), .load_memwb(load_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .pc_sel(pc_sel), .stall(stall), .mem_timeout(mem_timeout),
    .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_loaduse(perf_loaduse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctl_vec();
    return {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
            flush_ifid, flush_idex, pc_sel, stall};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge (inputs change here).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait to the falling edge for sampling.
  task automatic mid();
    #4;
  endtask

  task automatic idle();
    imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    ex_valid = 1'b0; ex_br_taken = 1'b0; ex_is_load = 1'b0;
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset values ----------------
    rst = 1'b1;
    idle();
    tick();
    mid();
    chk("reset_ctl", {23'd0, ctl_vec()}, {23'd0, V_RESET});
    tick();
    mid();
    chk("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("reset_perf_stall", perf_stall, 32'd0);
    chk("reset_state", {30'd0, dut.state_q}, {30'd0, RUN});
    tick();
    rst = 1'b0;

    // ---------------- steady flow ----------------
    imem_read = 1'b1; imem_resp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("steady_ctl", {23'd0, ctl_vec()}, {23'd0, V_RUN});
      tick();
    end
    mid();
    chk("steady_perf_stall", perf_stall, 32'd0);
    tick();

    // ---------------- load-use ----------------
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
    mid();
    chk("loaduse_rs1", {23'd0, ctl_vec()}, {23'd0, V_BUBBLE});
    tick();
    ex_valid = 1'b0;
    mid();
    chk("loaduse_after", {23'd0, ctl_vec()}, {23'd0, V_RUN});
    chk("loaduse_perf1", perf_loaduse, PERF);
    tick();
    ex_valid = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    mid();
    chk("loaduse_x0", {23'd0, ctl_vec()}, {23'd0, V_RUN});
    tick();
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
    mid();
    chk("loaduse_rs1_unused", {23'd0, ctl_vec()}, {23'd0, V_RUN});
    tick();
    id_use_rs2 = 1'b1; id_rs2 = 5'd5;
    mid();
    chk("loaduse_rs2", {23'd0, ctl_vec()}, {23'd0, V_BUBBLE});
    tick();
    idle();
    imem_read = 1'b1; imem_resp = 1'b1;
    mid();
    chk("loaduse_perf2", perf_loaduse, 2 * PERF);
    tick();

    // ---------------- dmem stall ----------------
    do_reset();
    dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("dmem_stall_ctl", {23'd0, ctl_vec()}, {23'd0, V_FREEZE});
      tick();
    end
    dmem_resp = 1'b1;
    mid();
    chk("dmem_resume_ctl", {23'd0, ctl_vec()}, {23'd0, V_RUN});
    chk("dmem_perf_stall", perf_stall, 3 * PERF);
    tick();
    idle();
    mid();
    chk("dmem_state_run", {30'd0, dut.state_q}, {30'd0, RUN});
    tick();

    // ---------------- redirect with outstanding fetch ----------------
    do_reset();
    ex_valid = 1'b1; ex_br_taken = 1'b1; imem_read = 1'b1; imem_resp = 1'b0;
    mid();
    chk("sq_wait0_ctl", {23'd0, ctl_vec()}, {23'd0, V_FREEZE});
    tick();
    mid();
    chk("sq_wait1_ctl", {23'd0, ctl_vec()}, {23'd0, V_FREEZE});
    chk("sq_state", {30'd0, dut.state_q}, {30'd0, SQUASH});
    tick();
    imem_resp = 1'b1;
    mid();
    chk("sq_resp_ctl", {23'd0, ctl_vec()}, {23'd0, V_REDIR});
    tick();
    idle();
    mid();
    chk("sq_back_run", {30'd0, dut.state_q}, {30'd0, RUN});
    chk("sq_run_ctl", {23'd0, ctl_vec()}, {23'd0, V_RUN});
    chk("sq_perf_flush", perf_flush, PERF);
    tick();

    // ---------------- redirect beats load-use ----------------
    do_reset();
    ex_valid = 1'b1; ex_br_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
    id_use_rs1 = 1'b1; id_rs1 = 5'd5;
    mid();
    chk("prio_ctl", {23'd0, ctl_vec()}, {23'd0, V_REDIR});
    tick();
    idle();
    mid();
    chk("prio_perf_flush", perf_flush, PERF);
    chk("prio_perf_loaduse", perf_loaduse, 32'd0);
    tick();

    // ---------------- held redirect across a dmem wait ----------------
    do_reset();
    ex_valid = 1'b1; ex_br_taken = 1'b1; dmem_req = 1'b1; dmem_resp = 1'b0;
    mid();
    chk("hold_redir_ctl", {23'd0, ctl_vec()}, {23'd0, V_FREEZE});
    tick();
    dmem_resp = 1'b1;
    mid();
    chk("hold_redir_apply", {23'd0, ctl_vec()}, {23'd0, V_REDIR});
    tick();

    // ---------------- watchdog ----------------
    do_reset();
    dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("wd_flag", {31'd0, mem_timeout}, (i >= 7) ? 32'd1 : 32'd0);
      tick();
    end
    dmem_resp = 1'b1;
    mid();
    chk("wd_resume_ctl", {23'd0, ctl_vec()}, {23'd0, V_RUN});
    chk("wd_flag_sticky0", {31'd0, mem_timeout}, 32'd1);
    tick();
    idle();
    mid();
    chk("wd_flag_sticky1", {31'd0, mem_timeout}, 32'd1);
    tick();

    // ---------------- reset mid-wait ----------------
    dmem_req = 1'b1; dmem_resp = 1'b0; ex_valid = 1'b1; ex_br_taken = 1'b1;
    tick();
    mid();
    chk("rstmid_wait_state", {30'd0, dut.state_q}, {30'd0, MEM_WAIT});
    tick();
    rst = 1'b1;
    mid();
    chk("rstmid_ctl", {23'd0, ctl_vec()}, {23'd0, V_RESET});
    tick();
    rst = 1'b0;
    idle();
    mid();
    chk("rstmid_state", {30'd0, dut.state_q}, {30'd0, RUN});
    chk("rstmid_flag", {31'd0, mem_timeout}, 32'd0);
    chk("rstmid_ctl_run", {23'd0, ctl_vec()}, {23'd0, V_RUN});
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
